gpio_msg_receiver: RTL and testbench
====================================

# gpio_msg_receiver

- Receiving end of the inter-FPGA GPIO message link.
- Captures a 128-bit message as four consecutive 32-bit words on the link data pins, then reassembles it.
- Buffers complete messages in a small FIFO and presents them to local logic over a valid/ready interface.
- Drives the link-side space and acknowledge lines so the peer transmitter never overruns it.

## Interface
- `DEPTH`, default 2: message FIFO depth in 128-bit entries; power of two, ≥2.
- `clock`  in  1: system clock, same clock the link is driven on; all logic on posedge.
- `resetn`  in  1: asynchronous, active-low reset.
- `link_data`  in  32: link data pins (GPIO[31:0]).
- `link_ready`  in  1: peer has a message in flight; held high from word 0 until it sees `link_ack`.
- `link_space`  out  1: receiver is idle and the FIFO has a free entry; peer starts a message only when this is high.
- `link_ack`  out  1: message fully captured; held until `link_ready` falls.
- `msg_data`  out  128: FIFO head; word 0 in [31:0], word 3 in [127:96].
- `msg_valid`  out  1: FIFO non-empty.
- `msg_ready`  in  1: consumer pops the head when `msg_valid` and `msg_ready` are both high.
- `rx_error`  out  1: one-cycle pulse when a message is aborted.
- `rx_msg_count`  out  16: status counter; see Configuration.
- `rx_err_count`  out  16: status counter; see Configuration.

## Operation
- Reset state: FSM in IDLE, FIFO empty, word index 0.
- Output values in reset:
  - `link_space`=1
  - `link_ack`=0
  - `msg_valid`=0
  - `msg_data`=0
  - `rx_error`=0
  - both counters 0
- FSM states:
  - IDLE: if `link_ready`=1 and `link_space`=1, capture `link_data` as word 0, set index=1 and go to BURST. Otherwise stay in IDLE.
  - BURST: if `link_ready`=0, discard the partial message, pulse `rx_error` and go to IDLE. Otherwise capture word[index]. If index=3, push the assembled message into the FIFO on the same edge and go to ACK; else index+1.
  - ACK: `link_ack`=1. When `link_ready`=0 is sampled, go to IDLE with index=0.
- `link_space` = (state==IDLE) & (FIFO count < DEPTH). It is combinational from registers and has no path from link inputs.
- Overflow cannot occur: space is checked at message start, and only pops can change the count during BURST.
- FIFO:
  - Pointers wrap modulo DEPTH; count runs 0..DEPTH.
  - Push and pop on the same edge leave the count unchanged.
  - Pop when empty is ignored.
  - `msg_data` holds its value while `msg_valid`=1 and `msg_ready`=0.
- The capture register is not cleared on abort; the next message overwrites all four words.

## Timing
- A message occupies 4 edges: E0 (IDLE→BURST, word 0) and E1..E3 (words 1..3). Push and the ACK transition happen at E3.
- `msg_valid` rises immediately after E3 if the FIFO was empty. Latency from word 0 sample to `msg_valid` is 3 cycles.
- `link_ack` is high from after E3 until one cycle after `link_ready` is sampled low.
- Minimum message period is 6 cycles: 4 data, at least 1 ACK, 1 IDLE.
- `link_ready` dropping at E1, E2 or E3 aborts the message. At E3 this means no push occurs.
- `link_ready` still high in IDLE after an abort starts a new message only if `link_space`=1.
- `resetn` asserted mid-message:
  - All state clears immediately.
  - Buffered messages are lost.
  - `link_ack` goes to 0 and `link_space` to 1.

## Configuration
- Macro: `GPIO_RX_STATUS_EN`.
- When defined:
  - `rx_msg_count` increments on every FIFO push.
  - `rx_err_count` increments on every `rx_error` pulse.
  - Both saturate at 16'hFFFF and clear on reset.
- When undefined: both ports are constant 0 and no counter flops are built.

## Test plan
- **Single message:** after reset, `link_ready`=1 with words 11111111, 22222222, 33333333, 44444444 on consecutive edges. Required: `msg_valid`=1 after the 4th edge, `msg_data`=128'h44444444_33333333_22222222_11111111, `link_ack`=1 until `link_ready` falls.
- **Full FIFO:** with DEPTH=2, send 2 messages while `msg_ready`=0. Required: `link_space`=0 and a held `link_ready` is not captured. Pop one entry; `link_space`=1 the next cycle and the third message is captured intact.
- **Abort:** drop `link_ready` after word 1. Required: `rx_error` pulses once, no push, state IDLE. A following message is received correctly, and `rx_err_count`=1 when `GPIO_RX_STATUS_EN` is defined.
- **Simultaneous push and pop:** FIFO holding 1 entry, pop on the same edge as E3. Required: count stays 1 and `msg_data` shows the new message.
- **Reset mid-message:** assert `resetn`=0 during BURST. Required: all outputs return to reset values asynchronously and no message appears after release.
- **Back-to-back:** send 6 messages at the 6-cycle period with `msg_ready`=1. Required: all 6 are delivered in order and `rx_msg_count`=6 when `GPIO_RX_STATUS_EN` is defined, else 0.

Source files
------------

// File: rtl/gpio_msg_receiver.sv
// rtl/gpio_msg_receiver.sv - GPIO link message receiver: 4x32-bit capture, message FIFO, valid/ready output
// Optional status counters built only when GPIO_RX_STATUS_EN is defined.
`timescale 1ns/1ps

module gpio_msg_receiver #(
    parameter int DEPTH = 2
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic [31:0]  link_data,
    input  logic         link_ready,
    output logic         link_space,
    output logic         link_ack,
    output logic [127:0] msg_data,
    output logic         msg_valid,
    input  logic         msg_ready,
    output logic         rx_error,
    output logic [15:0]  rx_msg_count,
    output logic [15:0]  rx_err_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [1:0]     r_idx;
    logic [1:0]     w_idx_nxt;
    logic [95:0]    r_cap;
    logic           w_cap_en;
    logic           w_push;
    logic           w_pop;
    logic           w_abort;
    logic           r_rx_error;
    logic [127:0]   w_push_data;

    logic [127:0]   r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           w_fifo_has_room;

    // link_space must depend only on registers so the peer sees no combinational loop
    assign w_fifo_has_room = (r_count < CW'(DEPTH));
    assign link_space      = (r_state == S_IDLE) && w_fifo_has_room;
    assign link_ack        = (r_state == S_ACK);
    assign msg_valid       = (r_count != '0);
    assign msg_data        = msg_valid ? r_mem[r_rd_ptr] : '0;
    assign rx_error        = r_rx_error;
    assign w_pop           = msg_valid && msg_ready;
    assign w_push_data     = {link_data, r_cap};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_idx      <= 2'd0;
            r_rx_error <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_rx_error <= w_abort;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cap_en    = 1'b0;
        w_push      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (link_ready && link_space) begin
                    w_cap_en    = 1'b1;
                    w_idx_nxt   = 2'd1;
                    w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                if (!link_ready) begin
                    w_abort     = 1'b1;
                    w_idx_nxt   = 2'd0;
                    w_state_nxt = S_IDLE;
                end else if (r_idx == 2'd3) begin
                    // word 3 goes straight from the pins into the FIFO entry
                    w_push      = 1'b1;
                    w_idx_nxt   = 2'd0;
                    w_state_nxt = S_ACK;
                end else begin
                    w_cap_en    = 1'b1;
                    w_idx_nxt   = r_idx + 2'd1;
                end
            end
            S_ACK: begin
                if (!link_ready) begin
                    w_idx_nxt   = 2'd0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_idx_nxt   = 2'd0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_cap <= '0;
        end else if (w_cap_en) begin
            case (r_idx)
                2'd0:    r_cap[31:0]  <= link_data;
                2'd1:    r_cap[63:32] <= link_data;
                2'd2:    r_cap[95:64] <= link_data;
                default: r_cap        <= r_cap;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef GPIO_RX_STATUS_EN
    logic [15:0] r_msg_cnt;
    logic [15:0] r_err_cnt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_msg_cnt <= 16'd0;
            r_err_cnt <= 16'd0;
        end else begin
            if (w_push && (r_msg_cnt != 16'hFFFF)) begin
                r_msg_cnt <= r_msg_cnt + 16'd1;
            end
            if (w_abort && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign rx_msg_count = r_msg_cnt;
    assign rx_err_count = r_err_cnt;
`else
    assign rx_msg_count = 16'd0;
    assign rx_err_count = 16'd0;
`endif

endmodule

// File: tb/tb_gpio_msg_receiver.sv
// tb/tb_gpio_msg_receiver.sv - directed self-checking bench for gpio_msg_receiver
`timescale 1ns/1ps

module tb_gpio_msg_receiver;

    logic         clock = 1'b0;
    logic         resetn = 1'b0;
    logic [31:0]  link_data = 32'd0;
    logic         link_ready = 1'b0;
    logic         msg_ready = 1'b0;
    logic         link_space;
    logic         link_ack;
    logic [127:0] msg_data;
    logic         msg_valid;
    logic         rx_error;
    logic [15:0]  rx_msg_count;
    logic [15:0]  rx_err_count;

    int n_cmp = 0;
    int n_err = 0;
    logic [127:0] rx_q [$];
    logic [127:0] exp_m [6];

`ifdef GPIO_RX_STATUS_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    always #5 clock = ~clock;

    gpio_msg_receiver #(.DEPTH(2)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .link_data    (link_data),
        .link_ready   (link_ready),
        .link_space   (link_space),
        .link_ack     (link_ack),
        .msg_data     (msg_data),
        .msg_valid    (msg_valid),
        .msg_ready    (msg_ready),
        .rx_error     (rx_error),
        .rx_msg_count (rx_msg_count),
        .rx_err_count (rx_err_count)
    );

    always @(negedge clock) begin
        if (resetn && msg_valid && msg_ready) begin
            rx_q.push_back(msg_data);
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [127:0] mk(input logic [31:0] w0, input logic [31:0] w1,
                                        input logic [31:0] w2, input logic [31:0] w3);
        return {w3, w2, w1, w0};
    endfunction

    // full 6-cycle message: 4 data edges, one ACK edge with ready held, one edge with ready low
    task automatic send(input logic [127:0] m);
        link_ready = 1'b1;
        link_data  = m[31:0];
        tick();
        link_data  = m[63:32];
        tick();
        link_data  = m[95:64];
        tick();
        link_data  = m[127:96];
        tick();
        link_data  = 32'd0;
        tick();
        link_ready = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] m1, m2, m3, m4, m5, m6, m7;
        m1 = mk(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
        m2 = mk(32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004);
        m3 = mk(32'hC3C30000, 32'hC3C30001, 32'hC3C30002, 32'hC3C30003);
        m4 = mk(32'hDEAD0000, 32'hBEEF0001, 32'hCAFE0002, 32'hF00D0003);
        m5 = mk(32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888);
        m6 = mk(32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210);
        m7 = mk(32'h99990000, 32'h99990001, 32'h99990002, 32'h99990003);

        // reset values
        tick();
        tick();
        chk("rst_space", 128'(link_space), 128'd1);
        chk("rst_ack",   128'(link_ack),   128'd0);
        chk("rst_valid", 128'(msg_valid),  128'd0);
        chk("rst_data",  msg_data,         128'd0);
        chk("rst_err",   128'(rx_error),   128'd0);
        chk("rst_mcnt",  128'(rx_msg_count), 128'd0);
        chk("rst_ecnt",  128'(rx_err_count), 128'd0);
        resetn = 1'b1;
        tick();

        // single message with latency checks
        link_ready = 1'b1;
        link_data  = 32'h11111111;
        tick();
        chk("e0_space", 128'(link_space), 128'd0);
        chk("e0_valid", 128'(msg_valid),  128'd0);
        link_data = 32'h22222222;
        tick();
        link_data = 32'h33333333;
        tick();
        chk("e2_valid", 128'(msg_valid), 128'd0);
        link_data = 32'h44444444;
        tick();
        chk("e3_valid", 128'(msg_valid), 128'd1);
        chk("e3_data",  msg_data,        m1);
        chk("e3_ack",   128'(link_ack),  128'd1);
        tick();
        chk("ack_hold", 128'(link_ack), 128'd1);
        link_ready = 1'b0;
        tick();
        chk("ack_drop",  128'(link_ack),   128'd0);
        chk("s1_space",  128'(link_space), 128'd1);

        // full FIFO: second message fills DEPTH=2, held ready is ignored
        send(m2);
        chk("full_space", 128'(link_space), 128'd0);
        chk("full_head",  msg_data,         m1);
        link_ready = 1'b1;
        link_data  = m3[31:0];
        tick();
        tick();
        tick();
        chk("full_ack",   128'(link_ack),   128'd0);
        chk("full_space2",128'(link_space), 128'd0);
        msg_ready = 1'b1;
        tick();
        msg_ready = 1'b0;
        chk("pop_space", 128'(link_space), 128'd1);
        chk("pop_head",  msg_data,         m2);
        send(m3);
        chk("m3_head", msg_data, m2);
        msg_ready = 1'b1;
        tick();
        msg_ready = 1'b0;
        chk("m3_data", msg_data, m3);
        msg_ready = 1'b1;
        tick();
        msg_ready = 1'b0;
        chk("m3_empty", 128'(msg_valid), 128'd0);

        // abort after word 1
        link_ready = 1'b1;
        link_data  = 32'hBAD00000;
        tick();
        link_data  = 32'hBAD00001;
        tick();
        link_ready = 1'b0;
        tick();
        chk("ab_err",   128'(rx_error),   128'd1);
        chk("ab_valid", 128'(msg_valid),  128'd0);
        chk("ab_space", 128'(link_space), 128'd1);
        tick();
        chk("ab_pulse", 128'(rx_error), 128'd0);
        send(m4);
        chk("ab_next",  msg_data, m4);
        chk("ab_ecnt",  128'(rx_err_count), STAT ? 128'd1 : 128'd0);
        msg_ready = 1'b1;
        tick();
        msg_ready = 1'b0;

        // abort on the last word: no push
        link_ready = 1'b1;
        link_data  = 32'hBAD10000;
        tick();
        tick();
        tick();
        link_ready = 1'b0;
        tick();
        chk("ab3_err",   128'(rx_error),  128'd1);
        chk("ab3_valid", 128'(msg_valid), 128'd0);
        chk("ab3_ack",   128'(link_ack),  128'd0);
        chk("ab3_ecnt",  128'(rx_err_count), STAT ? 128'd2 : 128'd0);

        // simultaneous push and pop with one entry buffered
        send(m5);
        link_ready = 1'b1;
        link_data  = m6[31:0];
        tick();
        link_data  = m6[63:32];
        tick();
        link_data  = m6[95:64];
        tick();
        link_data  = m6[127:96];
        msg_ready  = 1'b1;
        tick();
        msg_ready  = 1'b0;
        chk("pp_valid", 128'(msg_valid), 128'd1);
        chk("pp_data",  msg_data,        m6);
        link_ready = 1'b0;
        tick();
        msg_ready = 1'b1;
        tick();
        msg_ready = 1'b0;
        chk("pp_count1", 128'(msg_valid), 128'd0);

        // reset in the middle of a burst with one message buffered
        send(m7);
        link_ready = 1'b1;
        link_data  = 32'h77770000;
        tick();
        link_data  = 32'h77770001;
        tick();
        #2;
        resetn = 1'b0;
        #1;
        chk("mr_space", 128'(link_space), 128'd1);
        chk("mr_ack",   128'(link_ack),   128'd0);
        chk("mr_valid", 128'(msg_valid),  128'd0);
        chk("mr_data",  msg_data,         128'd0);
        chk("mr_mcnt",  128'(rx_msg_count), 128'd0);
        tick();
        link_ready = 1'b0;
        resetn     = 1'b1;
        tick();
        tick();
        tick();
        chk("mr_after", 128'(msg_valid), 128'd0);
        chk("mr_err",   128'(rx_error),  128'd0);

        // back-to-back at the 6-cycle period
        msg_ready = 1'b1;
        rx_q.delete();
        for (int i = 0; i < 6; i++) begin
            exp_m[i] = mk(32'hB0000000 + 32'(i * 16), 32'hB0000001 + 32'(i * 16),
                          32'hB0000002 + 32'(i * 16), 32'hB0000003 + 32'(i * 16));
            send(exp_m[i]);
        end
        tick();
        chk("b2b_count", 128'(rx_q.size()), 128'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < rx_q.size()) begin
                chk($sformatf("b2b_msg%0d", i), rx_q[i], exp_m[i]);
            end
        end
        chk("b2b_mcnt", 128'(rx_msg_count), STAT ? 128'd6 : 128'd0);
        chk("b2b_empty", 128'(msg_valid), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
